key_debounce: RTL

Single-key input conditioner for the board's LED demo designs: synchronizes an active-low push-button, filters contact bounce, and emits clean press, release and long-press events plus a debounced level. It is the input side of the LED panel: LED pattern controllers take its one-cycle event pulses instead of sampling raw pins.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_sync.sv | 26 ++
 rtl/key_debounce.sv | 135 +++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the single-key debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StPressFilt = 2'd1,
        StDown      = 2'd2,
        StRelFilt   = 2'd3
    } key_state_e;

    // Defaults assume a 50 MHz system clock: 20 ms debounce, 1 s long-press.
    localparam int unsigned DebCyclesDefault  = 1_000_000;
    localparam int unsigned LongCyclesDefault = 50_000_000;

endpackage

// File: rtl/key_sync.sv
// Generic 2-flop synchronizer for an asynchronous single-bit pin.
module key_sync #(
    parameter logic ResetValue = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: synchronize, debounce, and emit
// registered press / release / long-press pulses plus a debounced level.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DebCyclesDefault,
    parameter int unsigned LONG_CYCLES = LongCyclesDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DebLast  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HoldLast = HW'(LONG_CYCLES - 1);

    logic key_s;

    key_state_e    state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_done_q, long_done_d;
    logic          key_state_q, key_state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    key_sync #(
        .ResetValue (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (!key_s) state_d = StPressFilt;
            StPressFilt: begin
                if (key_s)                     state_d = StIdle;
                else if (deb_cnt_q == DebLast) state_d = StDown;
            end
            StDown:      if (key_s) state_d = StRelFilt;
            StRelFilt: begin
                if (!key_s)                    state_d = StDown;
                else if (deb_cnt_q == DebLast) state_d = StIdle;
            end
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            StIdle: deb_cnt_d = '0;
            StPressFilt: begin
                if (key_s) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    deb_cnt_d   = '0;
                    press_d     = 1'b1;
                    key_state_d = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            StDown: begin
                deb_cnt_d = '0;
                // Saturate at the threshold; long_done keeps the pulse single.
                if (hold_cnt_q != HoldLast) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (!long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
            end
            StRelFilt: begin
                if (!key_s) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    deb_cnt_d   = '0;
                    release_d   = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: deb_cnt_d = '0;
        endcase
    end

    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule
